buffer_drain: RTL and testbench

Downstream stage of the flash-to-buffer path. Once the 256×16 dual-port buffer has been filled, `buffer_drain` owns the buffer's read port. It fetches words in address order and presents each one to the CPU through memory-mapped IO registers. After the last word is consumed it issues a one-cycle `ack` pulse so the upstream controller can start the next flash transfer.

---
 rtl/buffer_drain_pkg.sv | 43 ++++
 rtl/buffer_drain_if.sv | 20 ++
 rtl/buffer_drain_fsm.sv | 123 ++++++++++++
 rtl/buffer_drain.sv | 112 +++++++++++
 tb/tb_buffer_drain.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/buffer_drain_pkg.sv
// Shared types and register map for the buffer drain block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package buffer_drain_pkg;

   // Drain sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_HOLD,
      ST_FINISH
   } state_t;

   // Register offsets from BASE_ADDR
   localparam logic [15:0] OFS_DATA   = 16'd0;
   localparam logic [15:0] OFS_STATUS = 16'd1;
   localparam logic [15:0] OFS_CKSUM  = 16'd2;

   // STATUS bit positions; count occupies [7:0]
   localparam int STAT_WORD_VALID = 15;
   localparam int STAT_DONE       = 14;
   localparam int STAT_UNDERRUN   = 13;

   // CONTROL bit positions (shares the STATUS address)
   localparam int CTRL_ABORT      = 0;
   localparam int CTRL_CLR_STICKY = 1;

   // Assemble the STATUS word from its fields
   function automatic logic [15:0] make_status(input logic       wv,
                                               input logic       done,
                                               input logic       underrun,
                                               input logic [7:0] cnt);
      logic [15:0] s;
      s                  = '0;
      s[STAT_WORD_VALID] = wv;
      s[STAT_DONE]       = done;
      s[STAT_UNDERRUN]   = underrun;
      s[7:0]             = cnt;
      return s;
   endfunction

endpackage

// File: rtl/buffer_drain_if.sv
// CPU memory-mapped IO bus as seen by the drain block.
// Latency: read data is combinational from the addressed register.
// Backpressure: none; every strobe completes in its own cycle.
interface buffer_drain_if;
   logic        Read_IO;
   logic        Write_IO;
   logic [15:0] Adress_bus;
   logic [15:0] io_wdata;
   logic [15:0] io_rdata;

   modport master (
      output Read_IO, Write_IO, Adress_bus, io_wdata,
      input  io_rdata
   );

   modport slave (
      input  Read_IO, Write_IO, Adress_bus, io_wdata,
      output io_rdata
   );
endinterface

// File: rtl/buffer_drain_fsm.sv
// Drain sequencer: state, read address, pop count, word_valid, done and ack.
// Latency: arm to word_valid 3 cycles; pop to next word_valid 3 cycles.
// Backpressure: holds each word until the CPU pops it; abort overrides a pop.
module buffer_drain_fsm
   import buffer_drain_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              irq,
   input  logic              data_rd,
   input  logic              abort,
   input  logic              clr_sticky,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] count,
   output logic              word_valid,
   output logic              capture,
   output logic              start,
   output logic              pop,
   output logic              ack,
   output logic              done
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              wv_q, wv_d;
   logic              ack_q, ack_d;
   logic              done_q, done_d;
   // Set when a drain completes; IDLE will not re-arm until irq is seen low
   logic              need_low_q, need_low_d;

   // Next-state, counter and strobe logic
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      wv_d       = wv_q;
      ack_d      = 1'b0;
      done_d     = done_q;
      need_low_d = need_low_q;
      capture    = 1'b0;
      start      = 1'b0;
      pop        = 1'b0;

      if (clr_sticky) done_d = 1'b0;
      if (!irq)       need_low_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (irq && !need_low_q) begin
               state_d = ST_FETCH;
               start   = 1'b1;
            end
         end
         ST_FETCH: state_d = ST_WAIT;
         ST_WAIT: begin
            capture = 1'b1;
            wv_d    = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (data_rd) begin
               pop     = 1'b1;
               wv_d    = 1'b0;
               addr_d  = addr_q + 1'b1;
               count_d = count_q + 1'b1;
               if (addr_q == '1) begin
                  state_d    = ST_FINISH;
                  ack_d      = 1'b1;
                  done_d     = 1'b1;
                  need_low_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Abort beats everything, including a pop in the same cycle
      if (abort) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         count_d = '0;
         wv_d    = 1'b0;
         ack_d   = 1'b0;
         capture = 1'b0;
         start   = 1'b0;
         pop     = 1'b0;
      end
   end

   // State and counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         wv_q       <= 1'b0;
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
         need_low_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         wv_q       <= wv_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         need_low_q <= need_low_d;
      end
   end

   assign rd_addr    = addr_q;
   assign count      = count_q;
   assign word_valid = wv_q;
   assign ack        = ack_q;
   assign done       = done_q;

endmodule

// File: rtl/buffer_drain.sv
// Drains the filled buffer to the CPU via DATA/STATUS/CONTROL/CHECKSUM IO registers.
// Latency: 3 cycles per word (fetch, RAM read, hold); io_rdata is combinational.
// Backpressure: words wait in the hold register until popped; BUFFER_DRAIN_CHECKSUM_EN adds the checksum.
module buffer_drain
   import buffer_drain_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int          DATA_W    = 16,
   parameter logic [15:0] BASE_ADDR = 16'h5002
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Interrupt_en,
   buffer_drain_if.slave     io,
   output logic [ADDR_W-1:0] buf_rd_addr,
   input  logic [DATA_W-1:0] buf_rd_data,
   output logic              word_valid,
   output logic              ack
);

   logic              sel_data, sel_stat, sel_cksum;
   logic              data_rd, ctrl_wr, abort, clr_sticky;
   logic              capture, start, pop, done;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              underrun_q, underrun_d;
   logic [15:0]       cksum_rd;
   logic [15:0]       rdata;
   logic              unused_bits;

   assign sel_data   = (io.Adress_bus == BASE_ADDR + OFS_DATA);
   assign sel_stat   = (io.Adress_bus == BASE_ADDR + OFS_STATUS);
   assign sel_cksum  = (io.Adress_bus == BASE_ADDR + OFS_CKSUM);
   assign data_rd    = io.Read_IO && sel_data;
   assign ctrl_wr    = io.Write_IO && sel_stat;
   assign abort      = ctrl_wr && io.io_wdata[CTRL_ABORT];
   assign clr_sticky = ctrl_wr && io.io_wdata[CTRL_CLR_STICKY];
   assign unused_bits = &{1'b0, io.io_wdata[15:2], pop, start};

   buffer_drain_fsm #(
      .ADDR_W (ADDR_W)
   ) u_fsm (
      .clock      (clock),
      .reset      (reset),
      .irq        (Interrupt_en),
      .data_rd    (data_rd),
      .abort      (abort),
      .clr_sticky (clr_sticky),
      .rd_addr    (buf_rd_addr),
      .count      (count),
      .word_valid (word_valid),
      .capture    (capture),
      .start      (start),
      .pop        (pop),
      .ack        (ack),
      .done       (done)
   );

   // Hold register loads the RAM word; a DATA read with nothing held sets underrun
   always_comb begin
      hold_d     = hold_q;
      underrun_d = underrun_q;
      if (capture)                 hold_d = buf_rd_data;
      if (clr_sticky)              underrun_d = 1'b0;
      if (data_rd && !word_valid)  underrun_d = 1'b1;
   end

   // Hold and underrun registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         underrun_q <= underrun_d;
      end
   end

`ifdef BUFFER_DRAIN_CHECKSUM_EN
   logic [15:0] cksum_q, cksum_d;

   // Running modulo-2^16 sum of popped words, restarted with each drain
   always_comb begin
      cksum_d = cksum_q;
      if (start || abort) cksum_d = '0;
      else if (pop)       cksum_d = cksum_q + 16'(hold_q);
   end

   // Checksum register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cksum_q <= '0;
      else        cksum_q <= cksum_d;
   end

   assign cksum_rd = cksum_q;
`else
   assign cksum_rd = 16'h0000;
`endif

   // Read mux: only the addressed register drives the bus during a read
   always_comb begin
      rdata = '0;
      if (io.Read_IO) begin
         if (sel_data)       rdata = 16'(hold_q);
         else if (sel_stat)  rdata = make_status(word_valid, done, underrun_q, 8'(count));
         else if (sel_cksum) rdata = cksum_rd;
      end
   end

   assign io.io_rdata = rdata;

endmodule

// File: tb/tb_buffer_drain.sv
// Directed bench for buffer_drain with a registered model RAM on port B.
// Latency: checks arm-to-valid and pop-to-ack timing against hand-derived cycles.
// Backpressure: CPU reads only when word_valid, except the deliberate underrun case.
module tb_buffer_drain;

   localparam logic [15:0] A_DATA  = 16'h5002;
   localparam logic [15:0] A_STAT  = 16'h5003;
   localparam logic [15:0] A_CKSUM = 16'h5004;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq;
   logic [7:0]  buf_rd_addr;
   logic [15:0] buf_rd_data;
   logic        word_valid;
   logic        ack;
   logic [15:0] mem [256];
   logic [15:0] d;
   int          vec_cnt     = 0;
   int          miscompares = 0;
   int          ack_cnt     = 0;

   buffer_drain_if bus ();

   buffer_drain dut (
      .clock        (clk),
      .reset        (rst_n),
      .Interrupt_en (irq),
      .io           (bus),
      .buf_rd_addr  (buf_rd_addr),
      .buf_rd_data  (buf_rd_data),
      .word_valid   (word_valid),
      .ack          (ack)
   );

   always #5 clk = ~clk;

   // registered RAM, one cycle read latency
   always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

   always @(negedge clk) if (ack) ack_cnt++;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // all bus tasks start and end at a falling edge
   task automatic cpu_read(input logic [15:0] a, output logic [15:0] rd);
      bus.Read_IO    = 1'b1;
      bus.Adress_bus = a;
      #1 rd = bus.io_rdata;
      @(negedge clk);
      bus.Read_IO = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] wd);
      bus.Write_IO   = 1'b1;
      bus.Adress_bus = a;
      bus.io_wdata   = wd;
      @(negedge clk);
      bus.Write_IO = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!word_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_vec(tag, {31'd0, word_valid}, 32'd1);
   endtask

   task automatic drain(input int n, input logic [15:0] base);
      logic [15:0] rd;
      for (int i = 0; i < n; i++) begin
         wait_valid($sformatf("wv[%0d]", i));
         cpu_read(A_DATA, rd);
         check_vec($sformatf("data[%0d]", i), {16'd0, rd}, {16'd0, base + 16'(i)});
      end
   endtask

   initial begin
      rst_n = 1'b0; irq = 1'b0;
      bus.Read_IO = 1'b0; bus.Write_IO = 1'b0; bus.Adress_bus = '0; bus.io_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
      repeat (3) @(negedge clk);

      // reset state
      check_vec("rst_wv",   {31'd0, word_valid}, 0);
      check_vec("rst_ack",  {31'd0, ack}, 0);
      check_vec("rst_addr", {24'd0, buf_rd_addr}, 0);
      cpu_read(A_STAT, d);
      check_vec("rst_stat", {16'd0, d}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // arm, then read DATA before a word is held
      irq = 1'b1;
      @(negedge clk);
      check_vec("fetch_addr", {24'd0, buf_rd_addr}, 0);
      check_vec("fetch_wv",   {31'd0, word_valid}, 0);
      cpu_read(A_DATA, d);
      check_vec("under_data", {16'd0, d}, 0);
      cpu_read(A_STAT, d);
      check_vec("under_stat", {16'd0, d}, 32'h2000);
      check_vec("wv_n3", {31'd0, word_valid}, 1);
      cpu_write(A_STAT, 16'h0002);
      cpu_read(A_STAT, d);
      check_vec("clr_stat", {16'd0, d}, 32'h8000);

      // full drain with irq held high
      drain(256, 16'hA000);
      check_vec("ack_hi", {31'd0, ack}, 1);
      @(negedge clk);
      check_vec("ack_lo", {31'd0, ack}, 0);
      check_vec("ack_cnt1", ack_cnt, 1);
      cpu_read(A_STAT, d);
      check_vec("done_stat", {16'd0, d}, 32'h4000);
      repeat (6) @(negedge clk);
      check_vec("no_rearm_wv", {31'd0, word_valid}, 0);
      check_vec("no_rearm_ack", ack_cnt, 1);

      // re-arm after irq low, pop 10, then abort
      irq = 1'b0;
      @(negedge clk);
      irq = 1'b1;
      drain(10, 16'hA000);
      wait_valid("wv_pre_abort");
      cpu_read(A_STAT, d);
      check_vec("stat_10", {16'd0, d}, 32'hC00A);
      bus.Read_IO = 1'b1; bus.Write_IO = 1'b1; bus.Adress_bus = A_STAT; bus.io_wdata = 16'h0001;
      irq = 1'b0;
      @(negedge clk);
      bus.Read_IO = 1'b0; bus.Write_IO = 1'b0;
      check_vec("abort_wv",   {31'd0, word_valid}, 0);
      check_vec("abort_addr", {24'd0, buf_rd_addr}, 0);
      check_vec("abort_ack",  {31'd0, ack}, 0);
      cpu_read(A_STAT, d);
      check_vec("abort_stat", {16'd0, d}, 32'h4000);
      cpu_write(A_STAT, 16'h0002);
      cpu_read(A_STAT, d);
      check_vec("clr2_stat", {16'd0, d}, 0);
      check_vec("abort_ackcnt", ack_cnt, 1);

      // async reset while word 37 is held
      irq = 1'b1;
      drain(37, 16'hA000);
      wait_valid("wv_37");
      bus.Read_IO = 1'b1; bus.Adress_bus = A_STAT;
      #1 check_vec("pre_rst_stat", {16'd0, bus.io_rdata}, 32'h8025);
      #1 rst_n = 1'b0;
      #1;
      check_vec("arst_wv",   {31'd0, word_valid}, 0);
      check_vec("arst_ack",  {31'd0, ack}, 0);
      check_vec("arst_addr", {24'd0, buf_rd_addr}, 0);
      check_vec("arst_stat", {16'd0, bus.io_rdata}, 0);
      bus.Adress_bus = A_DATA;
      #1 check_vec("arst_hold", {16'd0, bus.io_rdata}, 0);
      @(negedge clk);
      bus.Read_IO = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_vec("restart_addr", {24'd0, buf_rd_addr}, 0);
      drain(1, 16'hA000);

      // checksum over word[i]=i
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      rst_n = 1'b0; irq = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; irq = 1'b1;
      drain(256, 16'h0000);
      @(negedge clk);
      cpu_read(A_CKSUM, d);
`ifdef BUFFER_DRAIN_CHECKSUM_EN
      check_vec("cksum", {16'd0, d}, 32'h7F80);
`else
      check_vec("cksum", {16'd0, d}, 0);
`endif
      check_vec("ack_cnt_end", ack_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
